// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage.
// Size codes, FSM states and lane helpers.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic [7:0] lane_mask(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01 << off;
      SZ_H:    m = 8'h03 << off;
      SZ_W:    m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [2:0] m;
    m = (3'd1 << sz) - 3'd1;
    return (off & m) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus.
// Stage is master, memory is slave.
interface mem_access_stage_if #(
  parameter int DATA_W = 64
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_wstrb;
  logic                  dmem_ack;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and
// extract/extend for loads.
import mem_stage_pkg::*;

module mem_lane_align (
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_off,
  input  logic        i_unsigned,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_ldata
);
  logic [63:0] w_shift;
  logic        w_sx;

  assign w_shift = i_rdata >> {i_off, 3'b000};
  assign o_wstrb = lane_mask(i_size, i_off);

  // replicate store data, extract and extend load data
  always_comb begin
    o_wdata = i_store_data;
    o_ldata = w_shift;
    w_sx    = 1'b0;
    case (i_size)
      SZ_B: begin
        w_sx    = ~i_unsigned & w_shift[7];
        o_wdata = {8{i_store_data[7:0]}};
        o_ldata = {{56{w_sx}}, w_shift[7:0]};
      end
      SZ_H: begin
        w_sx    = ~i_unsigned & w_shift[15];
        o_wdata = {4{i_store_data[15:0]}};
        o_ldata = {{48{w_sx}}, w_shift[15:0]};
      end
      SZ_W: begin
        w_sx    = ~i_unsigned & w_shift[31];
        o_wdata = {2{i_store_data[31:0]}};
        o_ldata = {{32{w_sx}}, w_shift[31:0]};
      end
      default: begin
        o_wdata = i_store_data;
        o_ldata = w_shift;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the
// dmem bus, stalls, and registers results.
import mem_stage_pkg::*;

module mem_access_stage #(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              flush,
  output logic              stall,
  mem_access_stage_if.master dmem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_readdata,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_memtoreg,
  output logic              out_misaligned,
  output logic              out_bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_flushed;
  logic [DATA_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_isload;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_daddr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wstrb;

  logic              w_busy;
  logic              w_memop;
  logic              w_mis;
  logic              w_issue;
  logic              w_timeout;
  logic              w_we;
  logic              w_kill;
  logic              w_misout;
  logic [1:0]        w_size;
  logic [2:0]        w_off;
  logic [63:0]       w_wdata;
  logic [7:0]        w_wstrb;
  logic [63:0]       w_ldata;

  assign w_busy    = r_state == ST_BUSY;
  assign w_memop   = in_valid & (in_memread | in_memwrite);
  assign w_mis     = misaligned(in_size, in_alu_result[2:0]);
  assign w_issue   = ~w_busy & w_memop & ~w_mis & ~flush;
  assign w_timeout = w_busy & ~dmem.dmem_ack
                   & (r_cnt == CW'(TIMEOUT - 1));
  assign w_we      = in_memwrite & ~in_memread;
  assign w_kill    = r_flushed | flush;
  assign w_misout  = w_memop & w_mis & ~flush;
  assign stall     = w_issue
                   | (w_busy & ~dmem.dmem_ack & ~w_timeout);

  assign w_size = w_busy ? r_size : in_size;
  assign w_off  = w_busy ? r_addr[2:0] : in_alu_result[2:0];

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_daddr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_wstrb = r_wstrb;

  mem_lane_align u_align (
    .i_size       (w_size),
    .i_off        (w_off),
    .i_unsigned   (r_unsigned),
    .i_store_data (in_store_data),
    .i_rdata      (dmem.dmem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_ldata      (w_ldata)
  );

  // FSM, bus request and MEM/WB result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_flushed      <= 1'b0;
      r_addr         <= '0;
      r_size         <= '0;
      r_unsigned     <= 1'b0;
      r_isload       <= 1'b0;
      r_rd           <= '0;
      r_regwrite     <= 1'b0;
      r_memtoreg     <= 1'b0;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_daddr        <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      out_valid      <= 1'b0;
      out_readdata   <= '0;
      out_alu_result <= '0;
      out_rd         <= '0;
      out_regwrite   <= 1'b0;
      out_memtoreg   <= 1'b0;
      out_misaligned <= 1'b0;
      out_bus_err    <= 1'b0;
    end else if (!w_busy) begin
      out_readdata <= '0;
      out_bus_err  <= 1'b0;
      if (w_issue) begin
        r_state        <= ST_BUSY;
        r_cnt          <= '0;
        r_flushed      <= 1'b0;
        r_addr         <= in_alu_result;
        r_size         <= in_size;
        r_unsigned     <= in_unsigned;
        r_isload       <= in_memread;
        r_rd           <= in_rd;
        r_regwrite     <= in_regwrite;
        r_memtoreg     <= in_memtoreg;
        r_req          <= 1'b1;
        r_we           <= w_we;
        r_daddr        <= {in_alu_result[DATA_W-1:3], 3'b000};
        r_wdata        <= w_wdata;
        r_wstrb        <= w_we ? w_wstrb : 8'h00;
        out_valid      <= 1'b0;
        out_regwrite   <= 1'b0;
        out_misaligned <= 1'b0;
      end else begin
        out_valid      <= in_valid & ~flush;
        out_alu_result <= in_alu_result;
        out_rd         <= in_rd;
        out_memtoreg   <= in_memtoreg;
        out_misaligned <= w_misout;
        out_regwrite   <= in_valid & ~flush
                        & in_regwrite & ~w_misout;
      end
    end else begin
      out_misaligned <= 1'b0;
      if (flush) r_flushed <= 1'b1;
      if (dmem.dmem_ack) begin
        r_state        <= ST_IDLE;
        r_req          <= 1'b0;
        out_valid      <= ~w_kill;
        out_readdata   <= r_isload ? w_ldata : '0;
        out_alu_result <= r_addr;
        out_rd         <= r_rd;
        out_memtoreg   <= r_memtoreg;
        out_regwrite   <= r_regwrite & ~w_kill;
        out_bus_err    <= 1'b0;
      end else if (w_timeout) begin
        r_state        <= ST_IDLE;
        r_req          <= 1'b0;
        out_valid      <= 1'b1;
        out_readdata   <= '0;
        out_alu_result <= r_addr;
        out_rd         <= r_rd;
        out_memtoreg   <= r_memtoreg;
        out_regwrite   <= 1'b0;
        out_bus_err    <= 1'b1;
      end else begin
        r_cnt        <= r_cnt + 1'b1;
        out_valid    <= 1'b0;
        out_regwrite <= 1'b0;
        out_bus_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage:
// one-cycle vector table plus bus sequences.
module tb_mem_access_stage;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic [3:0]  in_rd;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_readdata;
  logic [63:0] out_alu_result;
  logic [3:0]  out_rd;
  logic        out_regwrite;
  logic        out_memtoreg;
  logic        out_misaligned;
  logic        out_bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if #(.DATA_W(64)) dif ();

  mem_access_stage #(
    .DATA_W(64), .REG_AW(4), .TIMEOUT(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_regwrite    (in_regwrite),
    .in_memtoreg    (in_memtoreg),
    .in_memread     (in_memread),
    .in_memwrite    (in_memwrite),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .flush          (flush),
    .stall          (stall),
    .dmem           (dif.master),
    .out_valid      (out_valid),
    .out_readdata   (out_readdata),
    .out_alu_result (out_alu_result),
    .out_rd         (out_rd),
    .out_regwrite   (out_regwrite),
    .out_memtoreg   (out_memtoreg),
    .out_misaligned (out_misaligned),
    .out_bus_err    (out_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  sz;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic        e_rw;
    logic        e_mis;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_memread  = 1'b0;
    in_memwrite = 1'b0;
    in_regwrite = 1'b0;
    in_memtoreg = 1'b0;
    flush       = 1'b0;
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = '0;
  endtask

  task automatic drive_mem(logic [63:0] a, logic [1:0] sz,
                           logic uns, logic rd_n,
                           logic wr_n);
    in_valid      = 1'b1;
    in_alu_result = a;
    in_size       = sz;
    in_unsigned   = uns;
    in_memread    = rd_n;
    in_memwrite   = wr_n;
    in_rd         = 4'd3;
    in_regwrite   = rd_n;
    in_memtoreg   = rd_n;
  endtask

  task automatic load_seq(string nm, logic [63:0] a,
                          logic [1:0] sz, logic uns,
                          logic [63:0] rdata, int ack_at,
                          logic [63:0] exp);
    int nst;
    logic done;
    logic [63:0] seen_addr;
    logic seen_req;
    nst = 0;
    done = 1'b0;
    seen_addr = '0;
    seen_req = 1'b0;
    drive_mem(a, sz, uns, 1'b1, 1'b0);
    for (int c = 0; c < 20 && !done; c++) begin
      dif.dmem_ack   = (c == ack_at);
      dif.dmem_rdata = (c == ack_at) ? rdata : 64'h0;
      #1;
      if (stall) nst++;
      if (c == ack_at) begin
        seen_addr = dif.dmem_addr;
        seen_req  = dif.dmem_req;
      end
      tick();
      if (out_valid) done = 1'b1;
    end
    idle_in();
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " readdata"}, out_readdata, exp);
    chk({nm, " regwrite"}, 64'(out_regwrite), 64'd1);
    chk({nm, " rd"}, 64'(out_rd), 64'd3);
    chk({nm, " stall_cycles"}, 64'(nst), 64'(ack_at));
    chk({nm, " req_at_ack"}, 64'(seen_req), 64'd1);
    chk({nm, " addr"}, seen_addr, {a[63:3], 3'b000});
    #1;
    chk({nm, " req_drop"}, 64'(dif.dmem_req), 64'd0);
  endtask

  initial begin
    vt[0] = '{1'b1, 64'h1234, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0,
              1'b0, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b0, 64'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 64'h3002, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 64'h2001, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 64'h10, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 64'h4004, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 64'h77, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 64'h3003, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    in_alu_result = '0;
    in_store_data = '0;
    in_rd = '0;
    in_size = '0;
    in_unsigned = 1'b0;
    idle_in();
    repeat (2) tick();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst req", 64'(dif.dmem_req), 64'd0);
    chk("rst alu", out_alu_result, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      in_valid      = vt[i].valid;
      in_alu_result = vt[i].alu;
      in_regwrite   = vt[i].rw;
      in_memread    = vt[i].mr;
      in_memwrite   = vt[i].mw;
      in_size       = vt[i].sz;
      flush         = vt[i].fl;
      in_rd         = 4'(i);
      #1;
      chk($sformatf("v%0d stall", i), 64'(stall),
          64'(vt[i].e_stall));
      tick();
      chk($sformatf("v%0d valid", i), 64'(out_valid),
          64'(vt[i].e_valid));
      chk($sformatf("v%0d regwrite", i), 64'(out_regwrite),
          64'(vt[i].e_rw));
      chk($sformatf("v%0d misaligned", i),
          64'(out_misaligned), 64'(vt[i].e_mis));
      chk($sformatf("v%0d alu", i), out_alu_result,
          vt[i].alu);
      chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(i));
      chk($sformatf("v%0d req", i), 64'(dif.dmem_req), 64'd0);
      chk($sformatf("v%0d rdata", i), out_readdata, 64'd0);
    end
    idle_in();
    tick();

    load_seq("LB", 64'h1003, 2'd0, 1'b0,
             64'h00000000_80000000, 4,
             64'hFFFF_FFFF_FFFF_FF80);
    load_seq("LBU", 64'h1003, 2'd0, 1'b1,
             64'h00000000_80000000, 1,
             64'h0000_0000_0000_0080);
    load_seq("LW", 64'h5004, 2'd2, 1'b0,
             64'h89ABCDEF_01234567, 2,
             64'hFFFF_FFFF_89AB_CDEF);
    load_seq("LHU", 64'h5002, 2'd1, 1'b1,
             64'h89ABCDEF_01234567, 1,
             64'h0000_0000_0000_0123);
    load_seq("LD", 64'h5008, 2'd3, 1'b0,
             64'h89ABCDEF_01234567, 3,
             64'h89ABCDEF_01234567);

    drive_mem(64'h2006, 2'd1, 1'b0, 1'b0, 1'b1);
    in_store_data = 64'hBEEF;
    #1;
    chk("SH stall", 64'(stall), 64'd1);
    tick();
    chk("SH addr", dif.dmem_addr, 64'h2000);
    chk("SH wstrb", 64'(dif.dmem_wstrb), 64'hC0);
    chk("SH wdata", 64'(dif.dmem_wdata[63:48]), 64'hBEEF);
    chk("SH we", 64'(dif.dmem_we), 64'd1);
    chk("SH req", 64'(dif.dmem_req), 64'd1);
    chk("SH busy valid", 64'(out_valid), 64'd0);
    dif.dmem_ack = 1'b1;
    #1;
    chk("SH stall on ack", 64'(stall), 64'd0);
    tick();
    idle_in();
    chk("SH out_valid", 64'(out_valid), 64'd1);
    chk("SH readdata", out_readdata, 64'd0);
    chk("SH alu", out_alu_result, 64'h2006);

    begin
      int nreq;
      int nst;
      logic done;
      nreq = 0;
      nst = 0;
      done = 1'b0;
      drive_mem(64'h6000, 2'd3, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 20 && !done; c++) begin
        #1;
        if (dif.dmem_req) nreq++;
        if (stall) nst++;
        tick();
        if (out_valid) done = 1'b1;
      end
      idle_in();
      chk("TO done", 64'(done), 64'd1);
      chk("TO busy cycles", 64'(nreq), 64'd4);
      chk("TO stall cycles", 64'(nst), 64'd4);
      chk("TO bus_err", 64'(out_bus_err), 64'd1);
      chk("TO regwrite", 64'(out_regwrite), 64'd0);
      chk("TO req", 64'(dif.dmem_req), 64'd0);
    end

    drive_mem(64'h7000, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk("FL req", 64'(dif.dmem_req), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("FL still req", 64'(dif.dmem_req), 64'd1);
    dif.dmem_ack = 1'b1;
    tick();
    idle_in();
    chk("FL out_valid", 64'(out_valid), 64'd0);
    chk("FL regwrite", 64'(out_regwrite), 64'd0);
    chk("FL req drop", 64'(dif.dmem_req), 64'd0);
    in_valid = 1'b1;
    in_alu_result = 64'h1234;
    in_regwrite = 1'b1;
    #1;
    chk("FL next stall", 64'(stall), 64'd0);
    tick();
    idle_in();
    chk("FL next valid", 64'(out_valid), 64'd1);
    chk("FL next alu", out_alu_result, 64'h1234);

    drive_mem(64'h8000, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk("RS req", 64'(dif.dmem_req), 64'd1);
    idle_in();
    reset = 1'b0;
    tick();
    chk("RS req", 64'(dif.dmem_req), 64'd0);
    chk("RS out_valid", 64'(out_valid), 64'd0);
    chk("RS alu", out_alu_result, 64'd0);
    chk("RS stall", 64'(stall), 64'd0);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
